// File: rtl/clock_pkg.sv
// Shared types and helpers for the clock_gen programmable divider.
// Divisor helpers are 64 bits wide; callers cast to their counter width.
package clock_pkg;

   localparam int unsigned DIV_W             = 64;
   localparam int unsigned CLK_DIV_N_DEFAULT = 5000000;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      STEP = 2'd2
   } clk_state_t;

   // A divisor of zero would stall the counter, so it runs as divide-by-one.
   function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
      return (d == '0) ? DIV_W'(1) : d;
   endfunction

endpackage

// File: rtl/clock_channel.sv
// One divider channel: counter, pending divisor, run/halt/step FSM and registered outputs.
// CLOCK_GEN_TICK_EN builds the tick flop; otherwise tick is tied low.
module clock_channel
   import clock_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DIV_DEFAULT = CLK_DIV_N_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_value,
   input  logic             run,
   input  logic             step,
   output logic             clk_div,
   output logic             clk_div_delay,
   output logic             tick,
   output logic             busy
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(eff_div(DIV_W'(DIV_DEFAULT)));

   clk_state_t       state;
   clk_state_t       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_pend;
   logic             pend;
   logic [CNT_W-1:0] half;
   logic             adv;
   logic             wrap;
   logic             rise;
   logic             dly_hit;

   // Divider timing decode and next-state logic.
   always_comb begin
      adv       = 1'b0;
      wrap      = 1'b0;
      rise      = 1'b0;
      dly_hit   = 1'b0;
      half      = div_act >> 1;
      state_nxt = state;

      adv     = (state != HALT);
      wrap    = adv && (cnt >= div_act - CNT_W'(1));
      rise    = wrap && !clk_div;
      dly_hit = adv && ((div_act == CNT_W'(1)) || (cnt == half - CNT_W'(1)));

      case (state)
         RUN:     if (!run) state_nxt = HALT;
         HALT:    if (run) state_nxt = RUN;
                  else if (step) state_nxt = STEP;
         STEP:    if (run) state_nxt = RUN;
                  else if (rise) state_nxt = HALT;
         default: state_nxt = HALT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= run ? RUN : HALT;
      else     state <= state_nxt;
   end

   // Counter, divisor reload and clock outputs; a new divisor only lands on a wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt           <= '0;
         div_act       <= DIV_RST;
         div_pend      <= '0;
         pend          <= 1'b0;
         clk_div       <= 1'b0;
         clk_div_delay <= 1'b0;
         busy          <= 1'b0;
      end else begin
         busy <= (state_nxt == STEP);
         if (adv) cnt <= wrap ? '0 : cnt + CNT_W'(1);
         if (wrap) begin
            clk_div <= !clk_div;
            if (pend) div_act <= div_pend;
         end
         if (dly_hit) clk_div_delay <= clk_div;
         if (div_load) begin
            div_pend <= CNT_W'(eff_div(DIV_W'(div_value)));
            pend     <= 1'b1;
         end else if (wrap) begin
            pend <= 1'b0;
         end
      end
   end

`ifdef CLOCK_GEN_TICK_EN
   always_ff @(posedge clk) begin
      if (rst) tick <= 1'b0;
      else     tick <= rise;
   end
`else
   assign tick = 1'b0;
`endif

endmodule

// File: rtl/clock_gen.sv
// Multi-channel runtime-programmable clock divider with run/halt/single-step control.
// Optional tick outputs are built when CLOCK_GEN_TICK_EN is defined.
module clock_gen
   import clock_pkg::*;
#(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned DIV_DEFAULT = CLK_DIV_N_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       div_load,
   input  logic [CHANNELS*CNT_W-1:0] div_value,
   input  logic                      run,
   input  logic                      step,
   output logic [CHANNELS-1:0]       clk_div,
   output logic [CHANNELS-1:0]       clk_div_delay,
   output logic [CHANNELS-1:0]       tick,
   output logic [CHANNELS-1:0]       busy
);

   // Channels share run/step but keep independent divisors and state.
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      clock_channel #(
         .CNT_W       (CNT_W),
         .DIV_DEFAULT (DIV_DEFAULT)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .div_load      (div_load[i]),
         .div_value     (div_value[i*CNT_W +: CNT_W]),
         .run           (run),
         .step          (step),
         .clk_div       (clk_div[i]),
         .clk_div_delay (clk_div_delay[i]),
         .tick          (tick[i]),
         .busy          (busy[i])
      );
   end

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: edge-schedule model plus directed literal checks.
module tb_clock_gen;

   localparam int CH   = 2;
   localparam int W    = 32;
   localparam int DEF  = 4;
   localparam int HMAX = 4096;
`ifdef CLOCK_GEN_TICK_EN
   localparam bit TICK_ON = 1'b1;
`else
   localparam bit TICK_ON = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            run;
   logic            step;
   logic [CH-1:0]   div_load;
   logic [CH*W-1:0] div_value;
   logic [CH-1:0]   clk_div;
   logic [CH-1:0]   clk_div_delay;
   logic [CH-1:0]   tick;
   logic [CH-1:0]   busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   clock_gen #(.CHANNELS(CH), .CNT_W(W), .DIV_DEFAULT(DEF)) dut (
      .clk           (clk),
      .rst           (rst),
      .div_load      (div_load),
      .div_value     (div_value),
      .run           (run),
      .step          (step),
      .clk_div       (clk_div),
      .clk_div_delay (clk_div_delay),
      .tick          (tick),
      .busy          (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: absolute advance count k, scheduled index of the next toggle, level history.
   typedef enum int {M_RUN, M_HALT, M_STEP} mst_t;
   int   m_k   [CH];
   int   m_nb  [CH];
   int   m_d   [CH];
   int   m_pv  [CH];
   int   m_chg [CH];
   bit   m_pend[CH];
   bit   m_lvl [CH];
   bit   m_rise[CH];
   bit   m_busy[CH];
   bit   m_fresh[CH];
   mst_t m_st  [CH];
   bit   hist  [CH][HMAX];
   bit   m_valid = 1'b0;

   function automatic int eff(input int v);
      return (v == 0) ? 1 : v;
   endfunction

   function automatic int lag(input int d);
      return ((d >> 1) < 1) ? 1 : (d >> 1);
   endfunction

   always @(posedge clk) begin : model
      int L;
      bit exp_d;
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_k[c] = 0; m_nb[c] = DEF; m_d[c] = DEF; m_pv[c] = 0; m_chg[c] = 0;
            m_pend[c] = 1'b0; m_lvl[c] = 1'b0; m_rise[c] = 1'b0; m_busy[c] = 1'b0;
            m_fresh[c] = 1'b1; hist[c][0] = 1'b0;
            m_st[c] = run ? M_RUN : M_HALT;
            m_valid = 1'b1;
         end else begin
            m_rise[c] = 1'b0;
            if (m_st[c] != M_HALT) begin
               m_k[c]++;
               if (m_k[c] == m_nb[c]) begin
                  m_rise[c] = !m_lvl[c];
                  m_lvl[c]  = !m_lvl[c];
                  if (m_pend[c]) begin
                     m_d[c] = m_pv[c]; m_pend[c] = 1'b0; m_chg[c] = m_k[c]; m_fresh[c] = 1'b0;
                  end
                  m_nb[c] = m_k[c] + m_d[c];
               end
               hist[c][m_k[c] % HMAX] = m_lvl[c];
            end
            if (div_load[c]) begin
               m_pend[c] = 1'b1;
               m_pv[c]   = eff(int'(div_value[c*W +: W]));
            end
            case (m_st[c])
               M_RUN:   if (!run) m_st[c] = M_HALT;
               M_HALT:  if (run) m_st[c] = M_RUN; else if (step) m_st[c] = M_STEP;
               default: if (run) m_st[c] = M_RUN; else if (m_rise[c]) m_st[c] = M_HALT;
            endcase
            m_busy[c] = (m_st[c] == M_STEP);
         end
      end
      #1;
      if (m_valid) begin
         for (int c = 0; c < CH; c++) begin
            chk($sformatf("m_clk_div[%0d]", c), 32'(clk_div[c]), 32'(m_lvl[c]));
            chk($sformatf("m_busy[%0d]", c), 32'(busy[c]), 32'(m_busy[c]));
            chk($sformatf("m_tick[%0d]", c), 32'(tick[c]), 32'(TICK_ON & m_rise[c]));
            if (m_fresh[c] || (m_k[c] >= m_chg[c] + m_d[c])) begin
               L = lag(m_d[c]);
               exp_d = (m_k[c] - L < 0) ? 1'b0 : hist[c][(m_k[c] - L) % HMAX];
               chk($sformatf("m_delay[%0d]", c), 32'(clk_div_delay[c]), 32'(exp_d));
            end
         end
      end
   end

   task automatic load(input int c, input int v);
      div_load    = '0;
      div_load[c] = 1'b1;
      div_value[c*W +: W] = W'(v);
      @(negedge clk);
      div_load = '0;
   endtask

   task automatic wait_ch0(input int rem, input bit lvl, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if ((m_nb[0] - m_k[0] == rem) && (m_lvl[0] == lvl)) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk(name, 32'(ok), 32'd1);
   endtask

   initial begin
      #60000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int  rises;
      int  falls;
      int  busy_cyc;
      int  n;
      bit  prev;
      rst = 1'b1; run = 1'b1; step = 1'b0; div_load = '0; div_value = '0;

      // Reset state and default divisor of 4.
      repeat (3) @(negedge clk);
      chk("rst_clk_div", 32'(clk_div), 32'd0);
      chk("rst_delay", 32'(clk_div_delay), 32'd0);
      chk("rst_tick", 32'(tick), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rise_not_before_4", 32'(clk_div), 32'd0);
      @(negedge clk);
      chk("first_rise_at_4", 32'(clk_div), 32'd3);
      chk("first_tick_at_4", 32'(tick), TICK_ON ? 32'd3 : 32'd0);
      @(negedge clk);
      chk("delay_lo_at_5", 32'(clk_div_delay), 32'd0);
      chk("tick_one_cycle", 32'(tick), 32'd0);
      @(negedge clk);
      chk("delay_hi_at_6", 32'(clk_div_delay), 32'd3);
      repeat (2) @(negedge clk);
      chk("fall_at_8", 32'(clk_div), 32'd0);
      repeat (4) @(negedge clk);
      chk("rise_at_12", 32'(clk_div), 32'd3);

      // Divide-by-one on ch0, zero divisor on ch1.
      load(0, 1);
      load(1, 0);
      repeat (30) @(negedge clk);

      // ch0 at 6, then two pending loads before the wrap; ch1 back to 4.
      load(0, 6);
      load(1, 4);
      repeat (20) @(negedge clk);
      wait_ch0(4, 1'b0, "wait_mid_period");
      load(0, 2);
      load(0, 3);
      repeat (40) @(negedge clk);

      // Halt with clk_div low, single step, second step while busy.
      wait_ch0(3, 1'b0, "wait_halt_low");
      run = 1'b0;
      repeat (4) @(negedge clk);
      step = 1'b1; @(negedge clk); step = 1'b0;
      rises = 0; busy_cyc = 0; prev = clk_div[0];
      for (int i = 0; i < 20; i++) begin
         if (busy[0]) busy_cyc++;
         if (i == 0) step = 1'b1;
         if (i == 1) step = 1'b0;
         @(negedge clk);
         if (clk_div[0] && !prev) rises++;
         prev = clk_div[0];
      end
      chk("step_lo_one_rise", 32'(rises), 32'd1);
      chk("step_lo_busy_cycles", 32'(busy_cyc), 32'd2);

      // Step from clk_div high at D=3: fall then rise, busy for 6 cycles.
      step = 1'b1; @(negedge clk); step = 1'b0;
      rises = 0; falls = 0; busy_cyc = 0; prev = clk_div[0];
      for (int i = 0; i < 12; i++) begin
         if (busy[0]) busy_cyc++;
         @(negedge clk);
         if (clk_div[0] && !prev) rises++;
         if (!clk_div[0] && prev) falls++;
         prev = clk_div[0];
      end
      chk("step_hi_busy_cycles", 32'(busy_cyc), 32'd6);
      chk("step_hi_rises", 32'(rises), 32'd1);
      chk("step_hi_falls", 32'(falls), 32'd1);

      // run rises mid-step and free-running resumes.
      step = 1'b1; @(negedge clk); step = 1'b0;
      repeat (2) @(negedge clk);
      run = 1'b1;
      repeat (40) @(negedge clk);

      // Reset during a step restores the default divisor.
      run = 1'b0;
      repeat (4) @(negedge clk);
      step = 1'b1; @(negedge clk); step = 1'b0;
      chk("busy_before_rst", 32'(busy[0]), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_step_clk_div", 32'(clk_div), 32'd0);
      chk("rst_step_delay", 32'(clk_div_delay), 32'd0);
      chk("rst_step_tick", 32'(tick), 32'd0);
      chk("rst_step_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      run = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (clk_div == 2'b11) break;
      end
      chk("rst_default_rise_edges", 32'(n), 32'd5);
      repeat (20) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
